// File: rtl/store_pkg.sv
// Shared definitions for the store unit: store-size encodings, FSM state type
// and the alignment/legality check applied when a request is accepted.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } state_e;

  // A store is rejected when its size is unknown or its address is not
  // naturally aligned to that size.
  function automatic logic isBadStore(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic bad;
    case (funct3)
      F3_SB:   bad = 1'b0;
      F3_SH:   bad = addrLo[0];
      F3_SW:   bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: overlays a byte or halfword of store data onto the
// old memory word at the lane selected by the low address bits (little-endian).
module store_merge
  import store_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] oldWord_i,
  input  logic [15:0]       data_i,
  input  logic [1:0]        addrLo_i,
  input  logic [2:0]        funct3_i,
  output logic [DWIDTH-1:0] merged_o
);

  logic [4:0] byteShift;
  logic [4:0] halfShift;

  assign byteShift = {addrLo_i, 3'b000};
  assign halfShift = {addrLo_i[1], 4'b0000};

  always_comb begin
    merged_o = oldWord_i;
    if (funct3_i == F3_SB) begin
      merged_o[byteShift +: 8] = data_i[7:0];
    end else if (funct3_i == F3_SH) begin
      merged_o[halfShift +: 16] = data_i;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts SB/SH/SW requests, performs read-modify-write for
// sub-word stores, and reports completion (and misalignment errors) with a pulse.
module store_unit
  import store_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_data_i,
  input  logic [2:0]        req_funct3_i,
  output logic              done_o,
  output logic              err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic [2:0]        funct3_q;
  logic              err_q;
  logic              respWait_q, respWait_d;
  logic [DWIDTH-1:0] mergedWord_q;
  logic [DWIDTH-1:0] mergedWord;
  logic              accept;
  logic              reqBad;

  assign reqBad = isBadStore(req_funct3_i, req_addr_i[1:0]);
  assign accept = req_ready_o && req_valid_i;

  store_merge #(
    .DWIDTH(DWIDTH)
  ) u_merge (
    .oldWord_i(mem_data_i),
    .data_i   (data_q[15:0]),
    .addrLo_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .merged_o (mergedWord)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      funct3_q     <= '0;
      err_q        <= 1'b0;
      respWait_q   <= 1'b0;
      mergedWord_q <= '0;
    end else begin
      state_q    <= state_d;
      respWait_q <= respWait_d;
      if (accept) begin
        addr_q   <= req_addr_i;
        data_q   <= req_data_i;
        funct3_q <= req_funct3_i;
        err_q    <= reqBad;
      end
      if (state_q == MERGE) begin
        mergedWord_q <= mergedWord;
      end
    end
  end

  // Errored requests sit in RESP for one extra cycle so that their completion
  // latency matches an aligned SW; no memory state is ever visited for them.
  always_comb begin
    state_d    = state_q;
    respWait_d = respWait_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (reqBad) begin
            state_d    = RESP;
            respWait_d = 1'b1;
          end else if (req_funct3_i == F3_SW) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:    state_d = MERGE;
      MERGE: state_d = WR;
      WR:    state_d = RESP;
      RESP: begin
        respWait_d = 1'b0;
        if (!respWait_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is qualified by rst so nothing leaks out while reset is held,
  // including a WR cycle that is being aborted.
  always_comb begin
    req_ready_o    = 1'b0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: req_ready_o = 1'b1;
        RD: begin
          mem_read_en_o = 1'b1;
          mem_addr_o    = {addr_q[AWIDTH-1:2], 2'b00};
        end
        WR: begin
          mem_write_en_o = 1'b1;
          mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
          mem_data_o     = (funct3_q == F3_SW) ? data_q : mergedWord_q;
        end
        RESP: begin
          done_o = !respWait_q;
          err_o  = !respWait_q && err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: a vector table of single stores against a
// small behavioural memory, plus hand-written reset-abort and back-to-back sequences.
module tb_store_unit;
  import store_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [2:0]  req_funct3_i;
  logic        done_o;
  logic        err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;

  logic [31:0] mem [0:1023];

  int checks;
  int errors;

  int          obsDoneCyc;
  int          obsDoneCount;
  logic        obsErr;
  int          obsWrites;
  int          obsWriteCyc;
  logic [31:0] obsWAddr;
  logic [31:0] obsWData;
  int          obsReads;
  logic [31:0] obsRAddr;
  int          obsZeroBad;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] initWord;
    logic        expErr;
    logic [31:0] expWord;
    int          expLat;
  } vec_t;

  store_unit #(
    .AWIDTH(32),
    .DWIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_funct3_i  (req_funct3_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_read_en_o (mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .mem_data_i    (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_read_en_o) mem_data_i <= mem[mem_addr_o[11:2]];
    if (mem_write_en_o) mem[mem_addr_o[11:2]] <= mem_data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Watch the DUT for a fixed number of cycles after an accept edge.
  task automatic observe(input int nCycles);
    obsDoneCyc   = 0;
    obsDoneCount = 0;
    obsErr       = 1'b0;
    obsWrites    = 0;
    obsWriteCyc  = 0;
    obsWAddr     = '0;
    obsWData     = '0;
    obsReads     = 0;
    obsRAddr     = '0;
    obsZeroBad   = 0;
    for (int cyc = 1; cyc <= nCycles; cyc++) begin
      @(negedge clk);
      if (mem_write_en_o) begin
        obsWrites++;
        obsWriteCyc = cyc;
        obsWAddr    = mem_addr_o;
        obsWData    = mem_data_o;
      end else if (mem_data_o !== 32'h0) begin
        obsZeroBad++;
      end
      if (mem_read_en_o) begin
        obsReads++;
        obsRAddr = mem_addr_o;
      end
      if (done_o) begin
        obsDoneCount++;
        if (obsDoneCyc == 0) begin
          obsDoneCyc = cyc;
          obsErr     = err_o;
        end
      end
    end
  endtask

  // Drive one request at a negedge; it is accepted on the following posedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    @(negedge clk);
    checkOutput("ready before request", {31'h0, req_ready_o}, 32'h1);
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    req_data_i   = data;
    req_funct3_i = f3;
    @(posedge clk);
    #1;
    req_valid_i  = 1'b0;
    req_addr_i   = 32'hFFFF_FFFF;
    req_data_i   = 32'h0F0F_0F0F;
    req_funct3_i = 3'b010;
  endtask

  // Abort a request by holding reset low across the edge after the accept.
  task automatic resetDuringOp(input string name, input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] f3, input logic [31:0] initWord);
    @(negedge clk);
    mem[addr[11:2]] = initWord;
    applyStimulus(addr, data, f3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput({name, " strobes gated"}, {30'h0, mem_read_en_o, mem_write_en_o}, 32'h0);
    checkOutput({name, " addr gated"}, mem_addr_o, 32'h0);
    checkOutput({name, " ready low in reset"}, {31'h0, req_ready_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput({name, " ready after release"}, {31'h0, req_ready_o}, 32'h1);
    observe(5);
    checkOutput({name, " no write"}, obsWrites, 0);
    checkOutput({name, " no done"}, obsDoneCount, 0);
    checkOutput({name, " memory intact"}, mem[addr[11:2]], initWord);
  endtask

  vec_t vecs [11];

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_data_i   = '0;
    req_funct3_i = '0;
    mem_data_i   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    vecs[0]  = '{32'h0000_0104, 32'hDEAD_BEEF, F3_SW, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[1]  = '{32'h0000_0202, 32'h0000_00AB, F3_SB, 32'h1122_3344, 1'b0, 32'h11AB_3344, 4};
    vecs[2]  = '{32'h0000_0302, 32'h0000_CAFE, F3_SH, 32'h1122_3344, 1'b0, 32'hCAFE_3344, 4};
    vecs[3]  = '{32'h0000_0102, 32'h1234_5678, F3_SW, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 2};
    vecs[4]  = '{32'h0000_0100, 32'h1234_5678, 3'b011, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, 2};
    vecs[5]  = '{32'h0000_0203, 32'h1234_5677, F3_SB, 32'h1122_3344, 1'b0, 32'h7722_3344, 4};
    vecs[6]  = '{32'h0000_0300, 32'hFFFF_BEEF, F3_SH, 32'hAABB_CCDD, 1'b0, 32'hAABB_BEEF, 4};
    vecs[7]  = '{32'h0000_0301, 32'h0000_1111, F3_SH, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE, 2};
    vecs[8]  = '{32'h0000_0208, 32'h0000_005A, F3_SB, 32'h0000_0000, 1'b0, 32'h0000_005A, 4};
    vecs[9]  = '{32'h0000_0110, 32'h0000_0001, 3'b111, 32'h0000_0042, 1'b1, 32'h0000_0042, 2};
    vecs[10] = '{32'h0000_0211, 32'h0000_00C3, F3_SB, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_C3FF, 4};

    // Reset state: everything quiet while rst is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", {31'h0, req_ready_o}, 32'h0);
    checkOutput("reset pulses", {30'h0, done_o, err_o}, 32'h0);
    checkOutput("reset strobes", {30'h0, mem_read_en_o, mem_write_en_o}, 32'h0);
    checkOutput("reset mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset mem_data", mem_data_o, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mem[vecs[i].addr[11:2]] = vecs[i].initWord;
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].f3);
      observe(7);
      checkOutput($sformatf("v%0d done latency", i), obsDoneCyc, vecs[i].expLat);
      checkOutput($sformatf("v%0d done count", i), obsDoneCount, 1);
      checkOutput($sformatf("v%0d err", i), {31'h0, obsErr}, {31'h0, vecs[i].expErr});
      checkOutput($sformatf("v%0d write count", i), obsWrites, vecs[i].expErr ? 0 : 1);
      checkOutput($sformatf("v%0d read count", i), obsReads,
                  (vecs[i].expErr || vecs[i].f3 == F3_SW) ? 0 : 1);
      checkOutput($sformatf("v%0d idle data zero", i), obsZeroBad, 0);
      checkOutput($sformatf("v%0d memory word", i), mem[vecs[i].addr[11:2]], vecs[i].expWord);
      if (!vecs[i].expErr) begin
        checkOutput($sformatf("v%0d write addr", i), obsWAddr, {vecs[i].addr[31:2], 2'b00});
        checkOutput($sformatf("v%0d write data", i), obsWData, vecs[i].expWord);
        checkOutput($sformatf("v%0d write cycle", i), obsWriteCyc, vecs[i].expLat - 1);
      end
      if (!vecs[i].expErr && vecs[i].f3 != F3_SW) begin
        checkOutput($sformatf("v%0d read addr", i), obsRAddr, {vecs[i].addr[31:2], 2'b00});
      end
    end

    resetDuringOp("rst in RD", 32'h0000_0602, 32'h0000_00AB, F3_SB, 32'h1122_3344);
    resetDuringOp("rst in WR", 32'h0000_0500, 32'h0BAD_F00D, F3_SW, 32'h1234_5678);

    // Valid held high with changing payload during an SB; only the captured one lands.
    begin
      int readyEarly;
      int writes;
      int doneCyc;
      logic [31:0] wWord;
      logic [31:0] wAddr;
      readyEarly = 0;
      writes     = 0;
      doneCyc    = 0;
      wWord      = '0;
      wAddr      = '0;
      @(negedge clk);
      mem[32'h204 >> 2] = 32'h1122_3344;
      req_valid_i  = 1'b1;
      req_addr_i   = 32'h0000_0205;
      req_data_i   = 32'h0000_0099;
      req_funct3_i = F3_SB;
      @(posedge clk);
      for (int cyc = 1; cyc <= 4; cyc++) begin
        #1;
        if (cyc < 4) begin
          req_addr_i   = 32'h0000_0700 + 32'(cyc * 4);
          req_data_i   = $urandom;
          req_funct3_i = F3_SW;
        end else begin
          req_addr_i   = 32'h0000_0400;
          req_data_i   = 32'h5555_AAAA;
          req_funct3_i = F3_SW;
        end
        @(negedge clk);
        if (req_ready_o) readyEarly++;
        if (mem_write_en_o) begin
          writes++;
          wWord = mem_data_o;
          wAddr = mem_addr_o;
        end
        if (done_o && doneCyc == 0) doneCyc = cyc;
        @(posedge clk);
      end
      checkOutput("held valid ready while busy", readyEarly, 0);
      checkOutput("held valid single write", writes, 1);
      checkOutput("held valid write data", wWord, 32'h1122_9944);
      checkOutput("held valid write addr", wAddr, 32'h0000_0204);
      checkOutput("held valid done latency", doneCyc, 4);
      @(negedge clk);
      checkOutput("next accept ready", {31'h0, req_ready_o}, 32'h1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("next write strobe", {31'h0, mem_write_en_o}, 32'h1);
      checkOutput("next write addr", mem_addr_o, 32'h0000_0400);
      checkOutput("next write data", mem_data_o, 32'h5555_AAAA);
      @(negedge clk);
      checkOutput("next done", {31'h0, done_o}, 32'h1);
      checkOutput("stray write absent", mem[32'h704 >> 2], 32'h0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  store request valid.
REQ-006 SHALL have port req_ready_o  output  1  unit can accept a request.
REQ-007 SHALL have port req_addr_i  input  AWIDTH  store byte address.
REQ-008 SHALL have port req_data_i  input  DWIDTH  store data, right-justified.
REQ-009 SHALL have port req_funct3_i  input  3  store size: 000 SB, 001 SH, 010 SW.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse with done_o on misaligned or illegal funct3.
REQ-012 SHALL have port mem_addr_o  output  AWIDTH  word-aligned memory address.
REQ-013 SHALL have port mem_data_o  output  DWIDTH  memory write data.
REQ-014 SHALL have port mem_read_en_o  output  1  memory read strobe.
REQ-015 SHALL have port mem_write_en_o  output  1  memory write strobe.
REQ-016 SHALL have port mem_data_i  input  DWIDTH  memory read data, valid the cycle after mem_read_en_o.

Function
REQ-017 SHALL implement FSM states IDLE, RD, MERGE, WR, RESP.
REQ-018 SHALL assert req_ready_o only in IDLE; a request is accepted when req_valid_i and req_ready_o are both high on a rising edge, which captures addr, data and funct3.
REQ-019 SHALL, from IDLE, go to WR for aligned SW, to RD for aligned SB or SH, and to RESP with error flagged for SH with addr[0]=1, SW with addr[1:0]!=0, or funct3 not in {000,001,010}.
REQ-020 SHALL drive mem_addr_o = {addr[AWIDTH-1:2],2'b00} in RD and WR, and zero otherwise.
REQ-021 SHALL assert mem_read_en_o for exactly one cycle, in RD; RD always goes to MERGE.
REQ-022 SHALL, in MERGE, register mem_data_i with the byte lane addr[1:0] replaced by data[7:0] (SB) or the halfword lane addr[1] replaced by data[15:0] (SH), little-endian, then go to WR.
REQ-023 SHALL assert mem_write_en_o for exactly one cycle, in WR, with mem_data_o = merged word (SB/SH) or captured data (SW); WR always goes to RESP.
REQ-024 SHALL hold mem_data_o at zero when mem_write_en_o is low.
REQ-025 SHALL pulse done_o in RESP for one cycle, plus err_o if flagged, then return to IDLE.
REQ-026 Latency from the accept edge to the done_o cycle SHALL be 2 cycles for SW and error, and 4 cycles for SB/SH.
REQ-027 SHALL never issue a memory access for an errored request.
REQ-028 SHALL ignore req_valid_i outside IDLE; input changes after acceptance SHALL NOT affect the operation in flight.
REQ-029 SHALL accept a new request in the first IDLE cycle after RESP, giving back-to-back SW throughput of one store per 3 cycles.

Reset
REQ-030 With rst=0 at a rising edge, SHALL enter IDLE and clear all captured registers.
REQ-031 While in reset, SHALL drive req_ready_o=0, and done_o, err_o, mem_read_en_o, mem_write_en_o, mem_addr_o and mem_data_o all 0.
REQ-032 Reset mid-operation, including in WR, SHALL abort with no write strobe on the following cycle and no done_o.

Structure
REQ-033 SHALL place funct3 constants (SB/SH/SW) and the state enum typedef in shared package store_pkg.
REQ-034 SHALL implement lane merge in combinational sub-module store_merge (inputs: old word, data, addr[1:0], funct3; output: merged word).

Verification
REQ-035 Scenario 1: SW addr=0x0000_0104, data=0xDEADBEEF -> one write at 0x104 with 0xDEADBEEF 1 cycle after accept, done_o 2 cycles after, no read.
REQ-036 Scenario 2: memory word 0x11223344 at 0x200; SB addr=0x202, data=0xAB -> read 0x200, write 0x11AB3344, done_o 4 cycles after accept.
REQ-037 Scenario 3: memory word 0x11223344 at 0x300; SH addr=0x302, data=0xCAFE -> write 0xCAFE3344.
REQ-038 Scenario 4: SW addr=0x0000_0102, then funct3=011 -> done_o and err_o each 2 cycles after accept, mem_read_en_o and mem_write_en_o never asserted.
REQ-039 Scenario 5: rst=0 asserted in the RD cycle of an SB -> no write, no done_o, req_ready_o=1 one cycle after rst returns to 1.
REQ-040 Scenario 6: req_valid_i held high with changing data during an SB -> only the captured request is written, the next request is accepted in the cycle after done_o.
